// File: rtl/uarc_bus_responder.sv
// Behavioural far end for TOTAL_BUSES UARC sender buses: per-bus handshake FSM with programmable ack latency.
// Optional macro UARC_RESPONDER_STREAM_BURST_EN: an acked stream keeps acking every cycle while held.

module uarc_bus_lane #(
    parameter int WW = 32,
    parameter int LW = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          kill,
    input  logic          incept,
    input  logic          send,
    input  logic          stream,
    input  logic [WW-1:0] data,
    input  logic [LW-1:0] latency,
    input  logic          ready,
    output logic [3:0]    acks,
    output logic          killed,
    output logic [WW-1:0] last_data,
    output logic [CW-1:0] count
);
`ifdef UARC_RESPONDER_STREAM_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD, S_STREAM} state_t;

    state_t        state;
    state_t        fire_state;
    logic [3:0]    cmd;
    logic [3:0]    win;
    logic [3:0]    fire_cmd;
    logic [LW-1:0] cnt;
    logic          req;
    logic          accept;
    logic          fire;
    logic          beat;
    logic          capture;

    // One-hot winner, bit order {stream, send, incept, kill}
    always_comb begin
        win = 4'b0000;
        if (en) begin
            if (kill)        win = 4'b0001;
            else if (incept) win = 4'b0010;
            else if (send)   win = 4'b0100;
            else if (stream) win = 4'b1000;
        end
    end

    assign req      = |win;
    assign accept   = req && ready && (!killed || win[0] || win[1]);
    assign fire_cmd = (state == S_IDLE) ? win : cmd;
    // Zero latency skips WAIT so the ack still lands L+1 cycles after the request
    assign fire     = ((state == S_IDLE) && accept && (latency == '0)) ||
                      ((state == S_WAIT) && req && (cnt == '0));
    assign beat     = (state == S_STREAM) && win[3];
    assign capture  = (fire && (fire_cmd[2] || fire_cmd[3])) || beat;
    assign fire_state = (BURST && fire_cmd[3]) ? S_STREAM : S_ACK;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            cmd       <= '0;
            cnt       <= '0;
            acks      <= '0;
            killed    <= 1'b0;
            last_data <= '0;
            count     <= '0;
        end else begin
            acks <= '0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cmd   <= win;
                        cnt   <= latency - LW'(1);
                        state <= (latency == '0) ? fire_state : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!req)            state <= S_IDLE;
                    else if (cnt == '0)  state <= fire_state;
                    else                 cnt   <= cnt - LW'(1);
                end
                S_ACK:    state <= S_HOLD;
                S_HOLD:   if (!req) state <= S_IDLE;
                S_STREAM: if (!win[3]) state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
            if (fire) begin
                acks <= fire_cmd;
                if (fire_cmd[0]) killed <= 1'b1;
                if (fire_cmd[1]) killed <= 1'b0;
            end
            if (beat) acks[3] <= 1'b1;
            if (capture) begin
                last_data <= data;
                if (~&count) count <= count + CW'(1);
            end
        end
    end
endmodule

module uarc_bus_responder #(
    parameter int WORD_MAG      = 5,
    parameter int TOTAL_BUSES   = 4,
    parameter int LATENCY_WIDTH = 4,
    parameter int COUNT_WIDTH   = 8
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      global_kill,
    input  logic                                      global_incept,
    input  logic                                      global_send,
    input  logic                                      global_stream,
    input  logic [(1<<WORD_MAG)-1:0]                  global_data,
    input  logic [TOTAL_BUSES-1:0]                    sender_enables,
    input  logic [LATENCY_WIDTH-1:0]                  cfg_latency,
    input  logic [TOTAL_BUSES-1:0]                    cfg_bus_ready,
    output logic [TOTAL_BUSES-1:0]                    sender_kill_acks,
    output logic [TOTAL_BUSES-1:0]                    sender_incept_acks,
    output logic [TOTAL_BUSES-1:0]                    sender_send_acks,
    output logic [TOTAL_BUSES-1:0]                    sender_stream_acks,
    output logic [TOTAL_BUSES-1:0]                    bus_killed,
    output logic [TOTAL_BUSES*(1<<WORD_MAG)-1:0]      last_data,
    output logic [TOTAL_BUSES*COUNT_WIDTH-1:0]        deliver_count
);
    localparam int WORD_WIDTH = 1 << WORD_MAG;

    logic [TOTAL_BUSES-1:0][3:0]             acks;
    logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0]  data_q;
    logic [TOTAL_BUSES-1:0][COUNT_WIDTH-1:0] count_q;

    for (genvar i = 0; i < TOTAL_BUSES; i++) begin : g_lane
        uarc_bus_lane #(
            .WW (WORD_WIDTH),
            .LW (LATENCY_WIDTH),
            .CW (COUNT_WIDTH)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .en        (sender_enables[i]),
            .kill      (global_kill),
            .incept    (global_incept),
            .send      (global_send),
            .stream    (global_stream),
            .data      (global_data),
            .latency   (cfg_latency),
            .ready     (cfg_bus_ready[i]),
            .acks      (acks[i]),
            .killed    (bus_killed[i]),
            .last_data (data_q[i]),
            .count     (count_q[i])
        );
    end

    always_comb begin
        for (int i = 0; i < TOTAL_BUSES; i++) begin
            sender_kill_acks[i]   = acks[i][0];
            sender_incept_acks[i] = acks[i][1];
            sender_send_acks[i]   = acks[i][2];
            sender_stream_acks[i] = acks[i][3];
        end
    end

    assign last_data     = data_q;
    assign deliver_count = count_q;
endmodule

// File: tb/tb_uarc_bus_responder.sv
// Scoreboard bench for uarc_bus_responder: expected acks/captures queued at stimulus, checked every cycle.
module tb_uarc_bus_responder;
    localparam int N = 4;
`ifdef UARC_RESPONDER_STREAM_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          global_kill = 1'b0, global_incept = 1'b0, global_send = 1'b0, global_stream = 1'b0;
    logic [31:0]   global_data = '0;
    logic [N-1:0]  sender_enables = '0;
    logic [3:0]    cfg_latency = '0;
    logic [N-1:0]  cfg_bus_ready = '1;
    logic [N-1:0]  sender_kill_acks, sender_incept_acks, sender_send_acks, sender_stream_acks;
    logic [N-1:0]  bus_killed;
    logic [127:0]  last_data;
    logic [31:0]   deliver_count;

    uarc_bus_responder dut (
        .clk(clk), .reset(reset),
        .global_kill(global_kill), .global_incept(global_incept),
        .global_send(global_send), .global_stream(global_stream),
        .global_data(global_data), .sender_enables(sender_enables),
        .cfg_latency(cfg_latency), .cfg_bus_ready(cfg_bus_ready),
        .sender_kill_acks(sender_kill_acks), .sender_incept_acks(sender_incept_acks),
        .sender_send_acks(sender_send_acks), .sender_stream_acks(sender_stream_acks),
        .bus_killed(bus_killed), .last_data(last_data), .deliver_count(deliver_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          bus;
        int          cmd;
        logic [31:0] data;
    } ev_t;

    ev_t              sb[$];
    int               cyc = 0;
    int               n_cmp = 0;
    int               n_bad = 0;
    bit               chk_en = 1'b0;
    logic [N-1:0]          m_killed = '0;
    logic [N-1:0][31:0]    m_data = '0;
    logic [N-1:0][7:0]     m_cnt = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: retire events due this cycle into the model, then compare every output
    logic [N-1:0] ek, ei, es, et;
    ev_t          e;
    always @(negedge clk) begin
        if (chk_en) begin
            ek = '0; ei = '0; es = '0; et = '0;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                chk("sb_cycle", 128'(e.cyc), 128'(cyc));
                case (e.cmd)
                    0: begin ek[e.bus] = 1'b1; m_killed[e.bus] = 1'b1; end
                    1: begin ei[e.bus] = 1'b1; m_killed[e.bus] = 1'b0; end
                    default: begin
                        if (e.cmd == 2) es[e.bus] = 1'b1;
                        else            et[e.bus] = 1'b1;
                        m_data[e.bus] = e.data;
                        if (m_cnt[e.bus] != 8'hFF) m_cnt[e.bus] = m_cnt[e.bus] + 8'd1;
                    end
                endcase
            end
            chk("kill_ack",   128'(sender_kill_acks),   128'(ek));
            chk("incept_ack", 128'(sender_incept_acks), 128'(ei));
            chk("send_ack",   128'(sender_send_acks),   128'(es));
            chk("stream_ack", 128'(sender_stream_acks), 128'(et));
            chk("bus_killed", 128'(bus_killed),         128'(m_killed));
            chk("last_data",  last_data,                m_data);
            chk("count",      128'(deliver_count),      128'(m_cnt));
        end
    end

    task automatic do_reset(input bit with_req);
        chk_en = 1'b0;
        reset  = 1'b0;
        if (with_req) begin
            sender_enables = 4'b0010;
            global_kill    = 1'b1;
            global_send    = 1'b1;
            cfg_latency    = '0;
        end
        tick();
        tick();
        chk("rst_kill_ack",   128'(sender_kill_acks), '0);
        chk("rst_send_ack",   128'(sender_send_acks), '0);
        chk("rst_bus_killed", 128'(bus_killed), '0);
        chk("rst_count",      128'(deliver_count), '0);
        chk("rst_last_data",  last_data, '0);
        sender_enables = '0;
        {global_stream, global_send, global_incept, global_kill} = 4'b0000;
        reset = 1'b1;
        sb.delete();
        m_killed = '0; m_data = '0; m_cnt = '0;
        tick();
        chk_en = 1'b1;
    endtask

    // cmds = {stream, send, incept, kill}; ready held low on the bus for the first 'stall' cycles
    task automatic do_req(input int bus, input logic [3:0] cmds, input int lat, input int hold,
                          input int stall, input logic [31:0] d0, input logic [31:0] step);
        int  win;
        ev_t ne;
        win = cmds[0] ? 0 : cmds[1] ? 1 : cmds[2] ? 2 : cmds[3] ? 3 : -1;
        if (win >= 0 && !(m_killed[bus] && win >= 2) && hold >= stall + lat + 1) begin
            ne.cyc = cyc + stall + lat + 1; ne.bus = bus; ne.cmd = win;
            ne.data = d0 + step * (stall + lat);
            sb.push_back(ne);
            if (BURST && win == 3) begin
                for (int j = stall + lat + 1; j < hold; j++) begin
                    ne.cyc = cyc + j + 1; ne.data = d0 + step * j;
                    sb.push_back(ne);
                end
            end
        end
        cfg_latency = 4'(lat);
        cfg_bus_ready = '1;
        {global_stream, global_send, global_incept, global_kill} = cmds;
        sender_enables = 4'(1 << bus);
        for (int j = 0; j < hold; j++) begin
            global_data = d0 + step * j;
            cfg_bus_ready[bus] = (j >= stall);
            if (j > stall) cfg_latency = 4'($urandom_range(0, 15));
            tick();
        end
        sender_enables = '0;
        {global_stream, global_send, global_incept, global_kill} = 4'b0000;
        cfg_bus_ready = '1;
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        // T1: reset with requests present
        do_reset(1'b1);
        // T2: send, latency 3
        do_req(1, 4'b0100, 3, 6, 0, 32'hDEADBEEF, 32'd0);
        // T3: priority, killed bus ignores send, incept revives
        do_req(0, 4'b0101, 0, 3, 0, 32'h11, 32'd0);
        do_req(0, 4'b0100, 0, 3, 0, 32'h22, 32'd0);
        do_req(0, 4'b1000, 2, 5, 0, 32'h23, 32'd0);
        do_req(0, 4'b0010, 0, 3, 0, 32'h33, 32'd0);
        do_req(0, 4'b0100, 2, 4, 0, 32'h44, 32'd1);
        // T4: abort in WAIT, then stall on ready
        do_req(2, 4'b0100, 5, 2, 0, 32'h66, 32'd0);
        do_req(2, 4'b0100, 2, 8, 3, 32'h55, 32'd1);
        do_req(2, 4'b1100, 4, 5, 0, 32'h70, 32'd1);
        // T5: stream, latency 1, data 1..4
        do_req(3, 4'b1000, 1, 4, 0, 32'd1, 32'd1);
        do_req(1, 4'b1000, 0, 6, 1, 32'h100, 32'd3);
        // T6: reset during WAIT, then saturation
        cfg_latency = 4'd8; sender_enables = 4'b0010; global_send = 1'b1; global_data = 32'hBAD;
        repeat (3) tick();
        do_reset(1'b0);
        repeat (12) tick();
        for (int k = 0; k < 260; k++) do_req(3, 4'b0100, 0, 1, 0, 32'(k), 32'd0);
        repeat (4) tick();
        chk("saturated", 128'(deliver_count[31:24]), 128'(8'hFF));
        chk("sb_empty", 128'(sb.size()), '0);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
